// File: rtl/ex_stage_pkg.sv
// Shared constants and payload types for the OpenMIPS execute stage.
// Opcode and result-class encodings match the OpenMIPS defines.v values.
package ex_stage_pkg;

  localparam int unsigned REG_W    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ALUOP_W  = 8;
  localparam int unsigned ALUSEL_W = 3;
  localparam int unsigned SHAMT_W  = 5;

  // Result classes
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;

  // Operations
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP = 8'b0000_1010;
  localparam logic [ALUOP_W-1:0] EXE_MOVN_OP = 8'b0000_1011;
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [ALUOP_W-1:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [ALUOP_W-1:0] EXE_MTLO_OP = 8'b0001_0011;

  // Decoded operation as latched in the EX input register
  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [REG_W-1:0]    reg1;
    logic [REG_W-1:0]    reg2;
    logic [ADDR_W-1:0]   wd;
    logic                wreg;
  } ex_op_t;

  // Register write-back payload (forwarding bus and MEM register)
  typedef struct packed {
    logic              wreg;
    logic [ADDR_W-1:0] wd;
    logic [REG_W-1:0]  wdata;
  } wb_t;

endpackage

// File: rtl/ex_stage_hilo_reg.sv
// HI/LO special registers with independent write enables.
// Ports: clk, rst (async active-high clear), we_hi/we_lo write enables,
//        hi_i/lo_i write data, hi_o/lo_o current register values.
import ex_stage_pkg::*;

module hilo_reg (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [REG_W-1:0] hi_i,
  input  logic [REG_W-1:0] lo_i,
  output logic [REG_W-1:0] hi_o,
  output logic [REG_W-1:0] lo_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      if (we_hi) hi_o <= hi_i;
      if (we_lo) lo_o <= lo_i;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// OpenMIPS execute stage: latches the decoded op from ID, evaluates
// logic/shift/move ops, owns HI/LO, forwards its in-flight result to ID and
// registers the result towards MEM.
// Ports: clk, rst (async active-high); stall_i holds EX and bubbles MEM;
//        id_* decoded operation in; ex_* combinational forwarding to ID;
//        mem_* registered result to MEM; hi_o/lo_o current HI/LO.
import ex_stage_pkg::*;

module ex_stage (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic [ALUOP_W-1:0]  id_aluop_i,
  input  logic [ALUSEL_W-1:0] id_alusel_i,
  input  logic [REG_W-1:0]    id_reg1_i,
  input  logic [REG_W-1:0]    id_reg2_i,
  input  logic [ADDR_W-1:0]   id_wd_i,
  input  logic                id_wreg_i,
  output logic                ex_wreg_o,
  output logic [ADDR_W-1:0]   ex_wd_o,
  output logic [REG_W-1:0]    ex_wdata_o,
  output logic                mem_wreg_o,
  output logic [ADDR_W-1:0]   mem_wd_o,
  output logic [REG_W-1:0]    mem_wdata_o,
  output logic [REG_W-1:0]    hi_o,
  output logic [REG_W-1:0]    lo_o
);

  ex_op_t ex_q;
  wb_t    mem_q;
  wb_t    ex_wb;

  logic [REG_W-1:0]   logic_res;
  logic [REG_W-1:0]   shift_res;
  logic [REG_W-1:0]   move_res;
  logic [REG_W-1:0]   result;
  logic [SHAMT_W-1:0] shamt;
  logic               we_hi;
  logic               we_lo;
  logic [REG_W-1:0]   hi_val;
  logic [REG_W-1:0]   lo_val;

  // EX input register: captures ID's op unless stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (!stall_i) begin
      ex_q <= '{aluop:  id_aluop_i,
                alusel: id_alusel_i,
                reg1:   id_reg1_i,
                reg2:   id_reg2_i,
                wd:     id_wd_i,
                wreg:   id_wreg_i};
    end
  end

  assign shamt = ex_q.reg1[SHAMT_W-1:0];

  // Logic unit
  always_comb begin
    logic_res = '0;
    case (ex_q.aluop)
      EXE_OR_OP:  logic_res = ex_q.reg1 | ex_q.reg2;
      EXE_AND_OP: logic_res = ex_q.reg1 & ex_q.reg2;
      EXE_XOR_OP: logic_res = ex_q.reg1 ^ ex_q.reg2;
      EXE_NOR_OP: logic_res = ~(ex_q.reg1 | ex_q.reg2);
      default:    logic_res = '0;
    endcase
  end

  // Shift unit: r2 shifted by r1[4:0]
  always_comb begin
    shift_res = '0;
    case (ex_q.aluop)
      EXE_SLL_OP: shift_res = ex_q.reg2 << shamt;
      EXE_SRL_OP: shift_res = ex_q.reg2 >> shamt;
      EXE_SRA_OP: shift_res = REG_W'($signed(ex_q.reg2) >>> shamt);
      default:    shift_res = '0;
    endcase
  end

  // Move unit: MOVN/MOVZ condition was resolved by ID into wreg
  always_comb begin
    move_res = '0;
    case (ex_q.aluop)
      EXE_MFHI_OP: move_res = hi_val;
      EXE_MFLO_OP: move_res = lo_val;
      EXE_MOVN_OP,
      EXE_MOVZ_OP: move_res = ex_q.reg1;
      default:     move_res = '0;
    endcase
  end

  // Result select by class
  always_comb begin
    result = '0;
    case (ex_q.alusel)
      EXE_RES_LOGIC: result = logic_res;
      EXE_RES_SHIFT: result = shift_res;
      EXE_RES_MOVE:  result = move_res;
      default:       result = '0;
    endcase
  end

  assign ex_wb = '{wreg: ex_q.wreg, wd: ex_q.wd, wdata: result};

  assign ex_wreg_o  = ex_wb.wreg;
  assign ex_wd_o    = ex_wb.wd;
  assign ex_wdata_o = ex_wb.wdata;

  // MEM output register: bubble while stalled so the held op reaches MEM once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (stall_i) begin
      mem_q <= '0;
    end else begin
      mem_q <= ex_wb;
    end
  end

  assign mem_wreg_o  = mem_q.wreg;
  assign mem_wd_o    = mem_q.wd;
  assign mem_wdata_o = mem_q.wdata;

  // HI/LO commit on the edge the op leaves EX, so a following MFHI/MFLO
  // reads the register directly
  assign we_hi = !stall_i && (ex_q.aluop == EXE_MTHI_OP);
  assign we_lo = !stall_i && (ex_q.aluop == EXE_MTLO_OP);

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .hi_i  (ex_q.reg1),
    .lo_i  (ex_q.reg1),
    .hi_o  (hi_val),
    .lo_o  (lo_val)
  );

  assign hi_o = hi_val;
  assign lo_o = lo_val;

endmodule
